amplitude_controller: RTL and testbench

Control block for the 8-bit amplitude selector in the waveform-generator datapath. Owns the 2-bit `amp_sel` register that sets output amplitude. In manual mode it debounces up/down push buttons and steps the setting, saturating at both ends. In sweep mode it steps the setting in a triangle pattern, paced by the generator's sample strobe.

---
 rtl/amplitude_controller.sv | 162 ++++++++++++++++
 tb/tb_amplitude_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/amplitude_controller.sv
// rtl/amplitude_controller.sv - 2-bit amplitude select: debounced manual stepping plus triangle sweep
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   btn_up       raw up button, asynchronous, active-high
//   btn_down     raw down button, asynchronous, active-high
//   sweep_en     1 = sweep mode, 0 = manual mode (synchronous level)
//   sample_tick  one-cycle strobe that paces the sweep
//   amp_sel      registered amplitude select
//   amp_changed  one-cycle pulse after amp_sel takes a new value
//   sweep_dir    registered sweep direction, 1 while sweeping down

module amplitude_controller #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SWEEP_TICKS     = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       sweep_en,
    input  logic       sample_tick,
    output logic [1:0] amp_sel,
    output logic       amp_changed,
    output logic       sweep_dir
);

    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TCW = (SWEEP_TICKS > 1) ? $clog2(SWEEP_TICKS) : 1;
    localparam logic [DCW-1:0] DB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(SWEEP_TICKS - 1);

    typedef enum logic [1:0] {
        MANUAL     = 2'd0,
        SWEEP_UP   = 2'd1,
        SWEEP_DOWN = 2'd2
    } state_t;

    // Button front end; bit 0 = up, bit 1 = down.
    logic [1:0]     btn_raw;
    logic [1:0]     sync_q1;
    logic [1:0]     sync_q2;
    logic [1:0]     btn_acc;
    logic [1:0]     btn_evt;
    logic [1:0]     db_done;
    logic [DCW-1:0] db_cnt [2];

    assign btn_raw = {btn_down, btn_up};

    // A debouncer completes when its count has reached the last value while
    // the synchronized level still disagrees with the accepted one.
    always_comb begin
        db_done = 2'b00;
        for (int i = 0; i < 2; i++) begin
            db_done[i] = (sync_q2[i] != btn_acc[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 2'b00;
            sync_q2 <= 2'b00;
            btn_acc <= 2'b00;
            btn_evt <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            // Only a 0->1 flip of the accepted level is a step event.
            btn_evt <= db_done & sync_q2;
            for (int i = 0; i < 2; i++) begin
                if (sync_q2[i] == btn_acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_done[i]) begin
                    btn_acc[i] <= sync_q2[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DCW'(1);
                end
            end
        end
    end

    logic up_evt;
    logic down_evt;

    assign up_evt   = btn_evt[0];
    assign down_evt = btn_evt[1];

    // Mode FSM and amplitude register.
    state_t         state;
    state_t         state_next;
    logic [1:0]     amp_next;
    logic [TCW-1:0] tick_cnt;
    logic [TCW-1:0] tick_next;

    always_comb begin
        state_next = state;
        amp_next   = amp_sel;
        tick_next  = tick_cnt;
        case (state)
            MANUAL: begin
                if (sweep_en) begin
                    state_next = (amp_sel == 2'd3) ? SWEEP_DOWN : SWEEP_UP;
                    tick_next  = '0;
                end else if (up_evt && !down_evt && amp_sel != 2'd3) begin
                    amp_next = amp_sel + 2'd1;
                end else if (down_evt && !up_evt && amp_sel != 2'd0) begin
                    amp_next = amp_sel - 2'd1;
                end
            end
            SWEEP_UP, SWEEP_DOWN: begin
                if (!sweep_en) begin
                    // Leaving sweep discards any tick arriving in this cycle.
                    state_next = MANUAL;
                    tick_next  = '0;
                end else if (sample_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next = '0;
                        if (state == SWEEP_UP) begin
                            amp_next = (amp_sel == 2'd3) ? amp_sel : amp_sel + 2'd1;
                            if (amp_sel >= 2'd2) begin
                                state_next = SWEEP_DOWN;
                            end
                        end else begin
                            amp_next = (amp_sel == 2'd0) ? amp_sel : amp_sel - 2'd1;
                            if (amp_sel <= 2'd1) begin
                                state_next = SWEEP_UP;
                            end
                        end
                    end else begin
                        tick_next = tick_cnt + TCW'(1);
                    end
                end
            end
            default: begin
                state_next = MANUAL;
                tick_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= MANUAL;
            amp_sel     <= 2'd0;
            tick_cnt    <= '0;
            amp_changed <= 1'b0;
            sweep_dir   <= 1'b0;
        end else begin
            state       <= state_next;
            amp_sel     <= amp_next;
            tick_cnt    <= tick_next;
            amp_changed <= (amp_next != amp_sel);
            sweep_dir   <= (state_next == SWEEP_DOWN);
        end
    end

endmodule

// File: tb/tb_amplitude_controller.sv
// tb/tb_amplitude_controller.sv - randomized directed bench for amplitude_controller
module tb_amplitude_controller;

    localparam int DC = 4;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       sweep_en = 1'b0;
    logic       sample_tick = 1'b0;
    logic [1:0] amp_sel;
    logic       amp_changed;
    logic       sweep_dir;

    int n_checks = 0;
    int n_fail   = 0;
    int chg_cnt  = 0;
    int exp_amp  = 0;
    int exp_chg  = 0;

    amplitude_controller #(
        .DEBOUNCE_CYCLES(DC),
        .SWEEP_TICKS    (ST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .sweep_en   (sweep_en),
        .sample_tick(sample_tick),
        .amp_sel    (amp_sel),
        .amp_changed(amp_changed),
        .sweep_dir  (sweep_dir)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (amp_changed === 1'b1) chg_cnt++;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Saturating manual step rule.
    function automatic int model_press(input int a, input bit up, input bit dn);
        if (up && !dn) return (a == 3) ? 3 : a + 1;
        if (dn && !up) return (a == 0) ? 0 : a - 1;
        return a;
    endfunction

    // Triangle 0,1,2,3,2,1,0,... indexed by completed sweep steps.
    function automatic int tri_val(input int p);
        int q;
        q = p % 6;
        return (q <= 3) ? q : 6 - q;
    endfunction

    function automatic int tri_dir(input int p);
        return ((p % 6) >= 3) ? 1 : 0;
    endfunction

    // Clean press: new value lands 2 + DC + 1 edges after the first sampling edge.
    task automatic press(input bit up, input bit dn, input string tag);
        int nxt;
        nxt = model_press(exp_amp, up, dn);
        btn_up   = up;
        btn_down = dn;
        steps(2 + DC);
        check({tag, "_pre"}, 32'(amp_sel), 32'(exp_amp));
        check({tag, "_prechg"}, 32'(amp_changed), 32'd0);
        step();
        check({tag, "_amp"}, 32'(amp_sel), 32'(nxt));
        check({tag, "_chg"}, 32'(amp_changed), 32'(nxt != exp_amp));
        step();
        check({tag, "_chgoff"}, 32'(amp_changed), 32'd0);
        if (nxt != exp_amp) exp_chg++;
        exp_amp = nxt;
        steps(int'($urandom_range(1, 4)));
        btn_up   = 1'b0;
        btn_down = 1'b0;
        steps(10);
        check({tag, "_hold"}, 32'(amp_sel), 32'(exp_amp));
    endtask

    initial begin
        int k;
        int gap;

        // Reset
        #2 rst = 1'b0;
        #1;
        check("rst_amp", 32'(amp_sel), 32'd0);
        check("rst_chg", 32'(amp_changed), 32'd0);
        check("rst_dir", 32'(sweep_dir), 32'd0);
        steps(2);
        rst = 1'b1;
        steps(2);
        chg_cnt = 0;

        // Manual stepping with saturation at both ends
        repeat (4) press(1'b1, 1'b0, "up");
        check("up_amp3", 32'(amp_sel), 32'd3);
        check("up_chgcnt", 32'(chg_cnt), 32'd3);
        repeat (4) press(1'b0, 1'b1, "down");
        check("down_amp0", 32'(amp_sel), 32'd0);
        check("down_chgcnt", 32'(chg_cnt), 32'd6);

        // Bouncy press never holds long enough
        repeat (5) begin
            btn_up = 1'b1;
            steps(3);
            btn_up = 1'b0;
            step();
        end
        steps(10);
        check("bounce_amp", 32'(amp_sel), 32'd0);
        check("bounce_chgcnt", 32'(chg_cnt), 32'(exp_chg));
        press(1'b1, 1'b0, "stable");

        // Simultaneous press
        press(1'b1, 1'b1, "both");

        // Random manual presses
        repeat (6) begin
            k = int'($urandom_range(0, 2));
            press(k != 1, k != 0, "rnd");
        end
        while (exp_amp != 0) press(1'b0, 1'b1, "dn0");
        check("manual_chgcnt", 32'(chg_cnt), 32'(exp_chg));

        // Sweep from 0 with button noise
        sweep_en = 1'b1;
        step();
        check("sw_entry_amp", 32'(amp_sel), 32'd0);
        check("sw_entry_dir", 32'(sweep_dir), 32'd0);
        for (int n = 1; n <= 26; n++) begin
            btn_up      = 1'($urandom_range(0, 1));
            btn_down    = 1'($urandom_range(0, 1));
            sample_tick = 1'b1;
            step();
            sample_tick = 1'b0;
            check("sw_amp", 32'(amp_sel), 32'(tri_val(n / ST)));
            check("sw_dir", 32'(sweep_dir), 32'(tri_dir(n / ST)));
            if (n % ST == 0) exp_chg++;
            gap = (n <= 21) ? 1 : int'($urandom_range(0, 3));
            steps(gap);
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        steps(10);
        check("sw_end_amp", 32'(amp_sel), 32'd2);
        check("sw_chgcnt", 32'(chg_cnt), 32'(exp_chg));

        // Exit with a tick that would otherwise have stepped to 3
        sweep_en    = 1'b0;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("exit_amp", 32'(amp_sel), 32'd2);
        check("exit_dir", 32'(sweep_dir), 32'd0);
        steps(5);
        check("exit_hold", 32'(amp_sel), 32'd2);
        check("exit_chgcnt", 32'(chg_cnt), 32'(exp_chg));

        // Manual to 3, then sweep starts downward
        exp_amp = 2;
        press(1'b1, 1'b0, "to3");
        sweep_en = 1'b1;
        step();
        check("sw3_dir", 32'(sweep_dir), 32'd1);
        check("sw3_amp", 32'(amp_sel), 32'd3);
        for (int n = 1; n <= ST; n++) begin
            sample_tick = 1'b1;
            step();
            sample_tick = 1'b0;
            check("sw3_step_amp", 32'(amp_sel), (n == ST) ? 32'd2 : 32'd3);
            step();
        end
        exp_chg++;
        check("sw3_step_dir", 32'(sweep_dir), 32'd1);
        check("sw3_chgcnt", 32'(chg_cnt), 32'(exp_chg));

        // Asynchronous reset mid-sweep at amp_sel = 2
        #2 rst = 1'b0;
        #1;
        check("arst_amp", 32'(amp_sel), 32'd0);
        check("arst_chg", 32'(amp_changed), 32'd0);
        check("arst_dir", 32'(sweep_dir), 32'd0);
        step();
        rst      = 1'b1;
        sweep_en = 1'b0;
        steps(3);
        check("post_rst_amp", 32'(amp_sel), 32'd0);
        check("post_rst_dir", 32'(sweep_dir), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
